// File: rtl/not_share_pkg.sv
// Shared types for the NOT-gate arbiter: FSM state encoding and pointer wrap helper.
// No logic of its own; latency and backpressure are defined by the users of this package.
package not_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_e;

    // Wrapping increment of the round-robin pointer over n requesters.
    function automatic int next_ptr(input int p, input int n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/not_share_arbiter_if.sv
// Requester, shared-gate and response signals of the NOT-gate arbiter.
// Latency is set by the arbiter; flow control is valid/ready on both the request and response sides.
interface not_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 1,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       REQ_VALID;
    logic [N_REQ*WIDTH-1:0] REQ_DATA;
    logic [N_REQ-1:0]       REQ_READY;
    logic [WIDTH-1:0]       GATE_A;
    logic [WIDTH-1:0]       GATE_Y;
    logic                   RSP_VALID;
    logic [ID_W-1:0]        RSP_ID;
    logic [WIDTH-1:0]       RSP_DATA;
    logic                   RSP_READY;

    // Environment side: requesters, the external gate and the response consumer.
    modport master (
        output REQ_VALID, REQ_DATA, GATE_Y, RSP_READY,
        input  REQ_READY, GATE_A, RSP_VALID, RSP_ID, RSP_DATA
    );

    // Arbiter side.
    modport slave (
        input  REQ_VALID, REQ_DATA, GATE_Y, RSP_READY,
        output REQ_READY, GATE_A, RSP_VALID, RSP_ID, RSP_DATA
    );
endinterface

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set request at or after ptr_i, wrapping.
// Purely combinational, zero latency; no backpressure of its own.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    int j;

    always_comb begin
        j     = 0;
        idx_o = '0;
        any_o = 1'b0;
        // Scan from farthest to nearest so the nearest set bit after ptr wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (req_i[j]) begin
                idx_o = ID_W'(j);
                any_o = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/not_share_arbiter.sv
// Shares one WIDTH-bit NOT gate among N_REQ requesters with round-robin grant.
// Latency: accept edge to RSP_VALID is 2 cycles; RSP_READY low holds the response and blocks new grants.
module not_share_arbiter
    import not_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 1,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    not_share_arbiter_if.slave    bus
);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] gate_a_q, gate_a_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_vld_q, rsp_vld_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic             accept;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req_i (bus.REQ_VALID),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gate_a_q   <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            rsp_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gate_a_q   <= gate_a_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_vld_q  <= rsp_vld_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gate_a_d   = gate_a_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_vld_d  = rsp_vld_q;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                accept = pick_any;
            end
            EVAL: begin
                rsp_data_d = bus.GATE_Y;
                rsp_vld_d  = 1'b1;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.RSP_READY) begin
                    rsp_vld_d = 1'b0;
                    accept    = pick_any;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A grant from IDLE or a back-to-back grant from RESP loads the gate operand.
        if (accept) begin
            gate_a_d = bus.REQ_DATA[pick_idx*WIDTH +: WIDTH];
            rsp_id_d = pick_idx;
            ptr_d    = ID_W'(next_ptr(int'(pick_idx), N_REQ));
            state_d  = EVAL;
        end
    end

    // Gated by RST_N so the accept strobe clears in the same cycle reset asserts.
    assign bus.REQ_READY = (accept && RST_N) ? pick_gnt : '0;
    assign bus.GATE_A    = gate_a_q;
    assign bus.RSP_VALID = rsp_vld_q;
    assign bus.RSP_ID    = rsp_id_q;
    assign bus.RSP_DATA  = rsp_data_q;

endmodule

// File: doc/not_share_arbiter.md
Name: not_share_arbiter

Overview:
- Shares one external NOT gate instance (WIDTH-bit bitwise inverter, Y = ~A) among N_REQ requesters.
- Picks one requester per transaction, round-robin. Drives the gate input from a register, captures the gate output into a response register and returns it with the requester index.
- Sits between the requester-side valid/ready interfaces and a single NOT primitive in the gates test designs.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 1, data bits per request; the shared gate is WIDTH bits wide.
- ID_W, $clog2(N_REQ), width of the RSP_ID field.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- REQ_VALID  input  N_REQ  per-requester request valid.
- REQ_DATA  input  N_REQ*WIDTH  per-requester operand; slice i is [i*WIDTH +: WIDTH].
- REQ_READY  output  N_REQ  one-hot accept; at most one bit high per cycle.
- GATE_A  output  WIDTH  registered operand to the shared NOT gate input.
- GATE_Y  input  WIDTH  shared NOT gate output (combinational from GATE_A).
- RSP_VALID  output  1  response valid.
- RSP_ID  output  ID_W  index of the requester that owns RSP_DATA.
- RSP_DATA  output  WIDTH  captured GATE_Y.
- RSP_READY  input  1  consumer accepts the response.

Behaviour:
- Reset (async assert, sync release), all outputs 0: REQ_READY=0, GATE_A=0, RSP_VALID=0, RSP_ID=0, RSP_DATA=0. State IDLE. Round-robin pointer PTR=0.
- FSM states: IDLE, EVAL, RESP.
- IDLE, some REQ_VALID set:
  - Grant g = first set bit searching PTR, PTR+1, ..., wrapping mod N_REQ.
  - REQ_READY[g]=1 combinationally in this cycle; the handshake completes on this edge.
  - Next: GATE_A <= REQ_DATA slice g, RSP_ID <= g, PTR <= (g+1) mod N_REQ, state EVAL.
- IDLE, no REQ_VALID: REQ_READY=0, stay in IDLE.
- EVAL: REQ_READY=0. Next: RSP_DATA <= GATE_Y, RSP_VALID <= 1, state RESP.
- RESP: RSP_VALID=1. RSP_ID and RSP_DATA are stable until the handshake.
  - RSP_READY=0: hold RESP. REQ_READY=0, GATE_A unchanged.
  - RSP_READY=1 and a REQ_VALID set: back-to-back. Arbitrate as in IDLE in the same cycle, assert REQ_READY[g], load GATE_A, RSP_ID and PTR, next EVAL. RSP_VALID <= 0.
  - RSP_READY=1 and no request: RSP_VALID <= 0, next IDLE.
- Timing:
  - Latency from request accept edge to RSP_VALID high: 2 cycles.
  - Peak throughput: 1 transaction per 2 cycles.
- REQ_VALID must stay high until REQ_READY for that requester. REQ_VALID dropping without a grant is tolerated; that requester is simply not granted.
- Fairness: a continuously requesting requester is granted within N_REQ transactions.
- PTR wrap: a grant of N_REQ-1 sets PTR=0.
- RST_N low in any state, including mid-EVAL or RESP: immediate return to reset values. The in-flight transaction is dropped and no response is produced.
- GATE_Y is sampled only in EVAL. GATE_Y values in other states have no effect.

Decomposition:
- Shared package not_share_pkg: state enum (IDLE, EVAL, RESP) and a next-pointer helper function (wrapping increment).
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs: request vector and PTR. Outputs: one-hot grant, grant index and any-request flag.
- Top module holds the FSM, PTR and the datapath registers.

Test Plan:
- Single request, N_REQ=4, WIDTH=4, requester 2 drives 4'b0101, RSP_READY=1:
  - REQ_READY=4'b0100 on cycle 0; GATE_A=4'b0101 on cycle 1.
  - RSP_VALID=1, RSP_ID=2, RSP_DATA=4'b1010 on cycle 2.
- All 4 requesters valid continuously, RSP_READY=1:
  - Grant order 0,1,2,3,0.
  - RSP_VALID high every other cycle; each RSP_DATA is the bitwise inverse of the matching operand.
- Backpressure: RSP_READY=0 for 5 cycles after response from requester 1 (data 4'b0011), with requester 3 pending:
  - RSP_DATA=4'b1100 and RSP_ID=1 held stable; REQ_READY=0 throughout.
  - Requester 3 granted in the cycle RSP_READY rises.
- Wrap: PTR=3 with requesters 0 and 3 valid -> requester 3 granted first, then requester 0; PTR ends at 1.
- Reset mid-operation: RST_N low during EVAL -> same-cycle async clear of RSP_VALID, GATE_A and REQ_READY. After release, no stale response appears and the next grant starts from requester 0.
